// File: rtl/johnson_phase_tracker.sv
// ============================================================================
// Module : johnson_phase_tracker
// Brief  : Validates and decodes a twisted-ring code, checks phase stepping,
//          counts revolutions and tracks lock.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module johnson_phase_tracker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int REV_W    = 8,
  localparam int PW      = $clog2(2*WIDTH)
) (
  input  logic               clk,
  input  logic               clear,
  input  logic [WIDTH-1:0]   cin,
  input  logic               cin_valid,
  output logic [PW-1:0]      phase,
  output logic [2*WIDTH-1:0] phase_onehot,
  output logic               phase_valid,
  output logic               wrap,
  output logic               restart,
  output logic [REV_W-1:0]   rev_count,
  output logic               illegal,
  output logic               seq_err,
  output logic               err_sticky,
  output logic               locked
);

  localparam int           NPH      = 2*WIDTH;
  localparam logic [PW:0]  C_NPH    = (PW+1)'(NPH);
  localparam logic [PW-1:0] C_LAST  = PW'(NPH-1);
  localparam logic [3:0]   C_LOCK   = 4'(LOCK_CNT);

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  state_t               state_q;
  logic [3:0]           lock_cnt_q;
  logic                 prev_valid_q;
  logic [PW-1:0]        phase_q;
  logic [NPH-1:0]       onehot_q;
  logic                 phase_valid_q;
  logic                 wrap_q;
  logic                 restart_q;
  logic [REV_W-1:0]     rev_q;
  logic                 illegal_q;
  logic                 seq_err_q;
  logic                 sticky_q;
  logic                 locked_q;

  logic [PW:0]          w_ones;
  logic [PW:0]          w_trans;
  logic                 w_legal;
  logic [PW:0]          w_neg;
  logic [PW-1:0]        w_phase;
  logic [PW-1:0]        w_next;
  logic                 w_hold;
  logic                 w_adv;
  logic                 w_zero;
  logic                 w_good;
  logic                 w_wrap;
  logic                 w_restart;

  // Ones count gives the phase directly when packed from the MSB; packed
  // from the LSB the phase counts backwards from 2*WIDTH.
  always_comb begin
    w_ones  = '0;
    w_trans = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_ones = w_ones + {{PW{1'b0}}, cin[i]};
    end
    for (int i = 0; i < WIDTH-1; i++) begin
      w_trans = w_trans + {{PW{1'b0}}, cin[i+1] ^ cin[i]};
    end
    w_legal = (w_trans <= (PW+1)'(1));
    w_neg   = C_NPH - w_ones;
    if (cin[WIDTH-1] || (w_ones == '0)) begin
      w_phase = w_ones[PW-1:0];
    end else begin
      w_phase = w_neg[PW-1:0];
    end
  end

  assign w_next    = (phase_q == C_LAST) ? '0 : phase_q + 1'b1;
  assign w_hold    = prev_valid_q && (w_phase == phase_q);
  assign w_adv     = prev_valid_q && (w_phase == w_next);
  assign w_zero    = (w_phase == '0);
  assign w_wrap    = w_adv && w_zero;
  assign w_restart = prev_valid_q && w_zero && !w_hold && !w_adv;
  assign w_good    = !prev_valid_q || w_hold || w_adv || w_restart;

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q       <= ST_UNLOCKED;
      lock_cnt_q    <= '0;
      prev_valid_q  <= 1'b0;
      phase_q       <= '0;
      onehot_q      <= '0;
      phase_valid_q <= 1'b0;
      wrap_q        <= 1'b0;
      restart_q     <= 1'b0;
      rev_q         <= '0;
      illegal_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      sticky_q      <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      wrap_q    <= 1'b0;
      restart_q <= 1'b0;
      illegal_q <= 1'b0;
      seq_err_q <= 1'b0;
      if (cin_valid) begin
        if (!w_legal) begin
          illegal_q     <= 1'b1;
          phase_valid_q <= 1'b0;
          onehot_q      <= '0;
          prev_valid_q  <= 1'b0;
          sticky_q      <= 1'b1;
          state_q       <= ST_UNLOCKED;
          lock_cnt_q    <= '0;
          locked_q      <= 1'b0;
        end else begin
          phase_q       <= w_phase;
          phase_valid_q <= 1'b1;
          onehot_q      <= NPH'(1) << w_phase;
          prev_valid_q  <= 1'b1;
          if (w_good) begin
            wrap_q    <= w_wrap;
            restart_q <= w_restart;
            if (w_wrap) begin
              rev_q <= rev_q + 1'b1;
            end
            if (state_q == ST_UNLOCKED) begin
              lock_cnt_q <= lock_cnt_q + 1'b1;
              if (lock_cnt_q + 1'b1 >= C_LOCK) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
              end
            end
          end else begin
            seq_err_q  <= 1'b1;
            sticky_q   <= 1'b1;
            state_q    <= ST_UNLOCKED;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
          end
        end
      end
    end
  end

  assign phase        = phase_q;
  assign phase_onehot = onehot_q;
  assign phase_valid  = phase_valid_q;
  assign wrap         = wrap_q;
  assign restart      = restart_q;
  assign rev_count    = rev_q;
  assign illegal      = illegal_q;
  assign seq_err      = seq_err_q;
  assign err_sticky   = sticky_q;
  assign locked       = locked_q;

endmodule

`default_nettype wire
